// File: rtl/hit_sensor_conditioner.sv
// hit_sensor_conditioner: turns three raw box sensors into clean single-cycle hit events
// Ports:
//   CLOCK_50       system clock, 50 MHz
//   reset          asynchronous, active-high
//   enable         game running; hits are accepted only while high
//   GPIO_1[2:0]    raw active-high sensor lines, asynchronous to CLOCK_50
//   hit_valid      one-cycle pulse per accepted hit
//   hit_box[2:0]   1/2/3 for sensor 0/1/2 of the last accepted hit, 0 = none since reset
//   multi_hit      set with hit_valid when more than one line rose in the accepting cycle
//   sensor_stable  debounced line levels
//   busy           high while in LOCKOUT or RELEASE
// Optional build macro HIT_STATS_EN adds saturating hit_count[7:0] and reject_count[7:0].
module hit_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LOCKOUT_CYCLES  = 5000000,
    parameter int CNT_W           = 23
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] GPIO_1,
    output logic       hit_valid,
    output logic [2:0] hit_box,
    output logic       multi_hit,
    output logic [2:0] sensor_stable,
    output logic       busy
`ifdef HIT_STATS_EN
    ,
    output logic [7:0] hit_count,
    output logic [7:0] reject_count
`endif
);
    localparam logic [1:0] ARMED   = 2'd0;
    localparam logic [1:0] LOCKOUT = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCKOUT_CYCLES - 1);

    logic [2:0]       meta, sync, stable, stable_q, rise, code;
    logic [CNT_W-1:0] cnt [3];
    logic [CNT_W-1:0] lock_cnt;
    logic [1:0]       state;
    logic             multi, accept;

    assign sensor_stable = stable;
    assign busy          = state != ARMED;
    assign rise          = stable & ~stable_q;
    assign code          = rise[0] ? 3'd1 : rise[1] ? 3'd2 : rise[2] ? 3'd3 : 3'd0;
    assign multi         = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
    assign accept        = enable && state == ARMED && |rise;

    // Synchroniser and per-line debounce; runs independently of enable and FSM state.
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) begin
            meta     <= '0;
            sync     <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            meta     <= GPIO_1;
            sync     <= meta;
            stable_q <= stable;
            for (int i = 0; i < 3; i++)
                if (sync[i] == stable[i]) cnt[i] <= '0;
                else if (cnt[i] == DEB_MAX) begin
                    stable[i] <= sync[i];
                    cnt[i]    <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
        end

    // Hit FSM: accept one strike, wait out the lockout, then wait for all lines
    // to settle low so a held sensor cannot retrigger.
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) begin
            state     <= ARMED;
            lock_cnt  <= '0;
            hit_valid <= 1'b0;
            hit_box   <= '0;
            multi_hit <= 1'b0;
        end else begin
            hit_valid <= 1'b0;
            if (!enable) begin
                state    <= ARMED;
                lock_cnt <= '0;
            end else if (state == ARMED) begin
                if (accept) begin
                    hit_valid <= 1'b1;
                    hit_box   <= code;
                    multi_hit <= multi;
                    lock_cnt  <= LOCK_MAX;
                    state     <= LOCKOUT;
                end
            end else if (state == LOCKOUT) begin
                if (lock_cnt == '0) state <= RELEASE;
                else lock_cnt <= lock_cnt - 1'b1;
            end else if (stable == 3'b000) state <= ARMED;
        end

`ifdef HIT_STATS_EN
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) begin
            hit_count    <= '0;
            reject_count <= '0;
        end else if (enable) begin
            if (accept && hit_count != 8'hff) hit_count <= hit_count + 1'b1;
            if (|rise && state != ARMED && reject_count != 8'hff) reject_count <= reject_count + 1'b1;
        end
`endif
endmodule

// File: tb/tb_hit_sensor_conditioner.sv
// tb_hit_sensor_conditioner: directed-vector bench for hit_sensor_conditioner (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8)
module tb_hit_sensor_conditioner;
    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] GPIO_1 = 3'b000;
    logic       hit_valid, multi_hit, busy;
    logic [2:0] hit_box, sensor_stable;
`ifdef HIT_STATS_EN
    logic [7:0] hit_count, reject_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    int p0;
    logic seen;

    hit_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(8), .CNT_W(23)) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .enable(enable),
        .GPIO_1(GPIO_1),
        .hit_valid(hit_valid),
        .hit_box(hit_box),
        .multi_hit(multi_hit),
        .sensor_stable(sensor_stable),
        .busy(busy)
`ifdef HIT_STATS_EN
        ,
        .hit_count(hit_count),
        .reject_count(reject_count)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        if (hit_valid) pulses++;
    endtask

    // Drive a clean rise and expect the pulse exactly 7 cycles later (2 sync + 4 debounce + 1 register).
    task automatic expect_hit(input string tag, input logic [2:0] g, input logic [2:0] box, input logic multi);
        GPIO_1 = g;
        repeat (6) tick();
        chk({tag, "_early"}, 32'(hit_valid), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        tick();
        chk({tag, "_valid"}, 32'(hit_valid), 1);
        chk({tag, "_box"}, 32'(hit_box), 32'(box));
        chk({tag, "_multi"}, 32'(multi_hit), 32'(multi));
        tick();
        chk({tag, "_one_cycle"}, 32'(hit_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", 32'(hit_valid), 0);
        chk("rst_box", 32'(hit_box), 0);
        chk("rst_multi", 32'(multi_hit), 0);
        chk("rst_stable", 32'(sensor_stable), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        enable = 1'b1;
        repeat (5) tick();

        p0 = pulses;
        expect_hit("single", 3'b010, 3'd2, 1'b0);
        chk("single_stable", 32'(sensor_stable), 32'(3'b010));
        repeat (22) tick();
        GPIO_1 = 3'b000;
        repeat (15) tick();
        chk("single_count", 32'(pulses - p0), 1);
        chk("single_rearmed", 32'(busy), 0);

        p0 = pulses;
        seen = 1'b0;
        GPIO_1 = 3'b001;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) GPIO_1 = 3'b000;
            tick();
            if (sensor_stable != 3'b000) seen = 1'b1;
        end
        chk("glitch_stable", 32'(seen), 0);
        chk("glitch_count", 32'(pulses - p0), 0);

        p0 = pulses;
        expect_hit("simul", 3'b101, 3'd1, 1'b1);
        repeat (10) tick();
        GPIO_1 = 3'b000;
        repeat (15) tick();
        chk("simul_count", 32'(pulses - p0), 1);
        chk("simul_rearmed", 32'(busy), 0);

        p0 = pulses;
        expect_hit("lock", 3'b001, 3'd1, 1'b0);
        GPIO_1 = 3'b101;
        repeat (32) tick();
        chk("lock_count", 32'(pulses - p0), 1);
        chk("lock_box_held", 32'(hit_box), 1);
        chk("lock_release_busy", 32'(busy), 1);
        GPIO_1 = 3'b000;
        repeat (15) tick();
        chk("lock_rearmed", 32'(busy), 0);
`ifdef HIT_STATS_EN
        chk("lock_rejects", 32'(reject_count), 1);
        chk("lock_hits", 32'(hit_count), 3);
`endif
        expect_hit("after_lock", 3'b100, 3'd3, 1'b0);
        GPIO_1 = 3'b000;
        repeat (20) tick();

        p0 = pulses;
        enable = 1'b0;
        GPIO_1 = 3'b010;
        repeat (15) tick();
        chk("gate_stable", 32'(sensor_stable), 32'(3'b010));
        chk("gate_count_off", 32'(pulses - p0), 0);
        chk("gate_box_held", 32'(hit_box), 3);
        enable = 1'b1;
        repeat (10) tick();
        chk("gate_count_on", 32'(pulses - p0), 0);
        chk("gate_busy", 32'(busy), 0);
        GPIO_1 = 3'b000;
        repeat (10) tick();

        expect_hit("prereset", 3'b001, 3'd1, 1'b0);
        tick();
        chk("prereset_busy", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("areset_box", 32'(hit_box), 0);
        chk("areset_busy", 32'(busy), 0);
        chk("areset_stable", 32'(sensor_stable), 0);
        chk("areset_valid", 32'(hit_valid), 0);
        GPIO_1 = 3'b000;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        p0 = pulses;
        expect_hit("postreset", 3'b010, 3'd2, 1'b0);
        chk("postreset_count", 32'(pulses - p0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
